if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
- Parametrised instruction-fetch stage and successor to the single-register fetch stage.
- Issues pipelined reads to a synchronous instruction SRAM with 1-cycle read latency.
- Buffers returned instructions in a FIFO of DEPTH entries, with a valid/ready handshake to ID.
- Supports branch redirect with queue flush and in-flight kill; flags misaligned-PC fetch exceptions.

Parameters:
- RESET_PC, 32'hbfc0_0000, first fetch address after reset.
- DEPTH, 4, prefetch queue entries; legal range 2..16. DEPTH>=3 sustains 1 instr/cycle.
- PTR_W, $clog2(DEPTH), queue pointer width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- br_bus  in  `BR_WD  {br_e, br_addr[31:0]}; br_e=1 redirects fetch to br_addr
- id_ready  in  1  ID accepts the head entry this cycle
- id_valid  out  1  queue head is valid
- id_pc  out  32  PC of head entry
- id_inst  out  32  instruction of head entry (0 when id_adel=1)
- id_adel  out  1  head entry has a misaligned-PC fetch exception
- inst_sram_en  out  1  read request this cycle
- inst_sram_wen  out  4  tied 4'b0
- inst_sram_addr  out  32  request address = fetch_pc
- inst_sram_wdata  out  32  tied 32'b0
- inst_sram_rdata  in  32  read data, valid the cycle after the request

Behaviour:
- Clocking: one clock domain; rst is sampled on the posedge and overrides everything else.
- Reset:
  - fetch_pc=RESET_PC; count=0; rd_ptr=wr_ptr=0; inflight=0; halted=0.
  - id_valid=0; inst_sram_en=0; id_pc, id_inst and id_adel=0 while queue is empty.
- Handshakes:
  - pop = id_valid & id_ready.
  - push = inflight & ~kill, occurring in the response cycle.
- Issue condition: issue = ~rst & ~br_e & ~halted & (count + inflight - pop < DEPTH).
- Issue action:
  - If fetch_pc[1:0]==0: inst_sram_en=1, addr=fetch_pc, and fetch_pc<=fetch_pc+4 (32-bit wrap, no carry-out).
  - If misaligned: inst_sram_en=0, a pseudo-request is recorded, and halted<=1.
- Request pipeline register:
  - Captures {inflight<=issue, req_pc<=fetch_pc, req_adel<=fetch_pc[1:0]!=0}.
  - The response cycle writes {req_pc, adel ? 0 : inst_sram_rdata, req_adel} to queue[wr_ptr].
- Latency: request in cycle t -> entry written end of t+1 -> id_valid=1 in t+2 (if the queue was empty).
- Queue:
  - Circular buffer; pointers wrap from DEPTH-1 to 0; count in [0,DEPTH].
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Push into a full queue cannot occur by the issue rule; the bench asserts this never happens.
- Outputs: id_pc, id_inst and id_adel reflect queue[rd_ptr] combinationally from registers, with no SRAM-to-ID combinational path.
- Redirect (br_e=1 in cycle t), highest priority after rst:
  - count<=0, rd_ptr<=wr_ptr<=0, and halted<=0.
  - kill: any response returning in cycle t is discarded and not pushed; pop in cycle t is ignored.
  - No issue in cycle t; fetch_pc<=br_addr; br_addr is issued in t+1.
  - A misaligned br_addr produces one adel entry, then halts.
- Halted state: no further issue until the next br_e or rst. Already-queued entries still drain.
- Stall: id_ready=0 holds the head stable (id_valid, id_pc, id_inst, id_adel unchanged). Fetch continues until the queue plus in-flight reaches DEPTH.

Test Plan:
- Reset release, id_ready=1, SRAM returns addr^32'h1111_1111 -> inst_sram_addr=bfc00000,bfc00004,... on consecutive cycles; id_valid first high 2 cycles after the first request; id_pc sequence bfc00000, bfc00004, ... with no bubbles (DEPTH=4).
- id_ready=0 for 10 cycles from reset -> exactly 4 entries queued, inst_sram_en low afterwards, head pc=bfc00000 constant; id_ready=1 -> drains 4 in order and issue resumes without gaps.
- br_e with br_addr=bfc00100 while 3 entries are queued and 1 request is in flight -> id_valid=0 next cycle; the killed response is not seen; next id_pc=bfc00100 two cycles after the reissue.
- br_addr=bfc00102 -> no SRAM request; one entry with id_adel=1, id_pc=bfc00102, id_inst=0; then id_valid=0 and inst_sram_en=0 until the next br_e=bfc00200 resumes fetching.
- Mid-run rst with a full queue -> next cycle id_valid=0 and count=0; the first request after release is at RESET_PC.
- DEPTH=2 and DEPTH=16 regressions with random id_ready and random br_e -> each popped pc is the predecessor+4 or the last br_addr; the queue never overflows.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch stage with a prefetch queue. Reads are issued to a
// synchronous instruction SRAM (1-cycle read latency) and the returned words
// are buffered in a DEPTH-entry circular queue that feeds ID.
//
// Handshake (ID side): the head entry is offered with id_valid; it is consumed
// in any cycle where id_valid and id_ready are both high, unless a redirect is
// taken in that same cycle (the flush wins and the pop is ignored). While
// id_ready is low the head entry and id_valid are held stable.
//
// Ports:
//   clk              clock
//   rst              synchronous reset, active-high
//   br_bus[32:0]     {br_e, br_addr}; br_e redirects fetch to br_addr
//   id_ready         ID accepts the head entry this cycle
//   id_valid         queue head is valid
//   id_pc[31:0]      PC of head entry (0 when the queue is empty)
//   id_inst[31:0]    instruction of head entry (0 for an adel entry or empty)
//   id_adel          head entry carries a misaligned-PC fetch exception
//   inst_sram_en     read request this cycle
//   inst_sram_wen    tied to 0 (read-only port)
//   inst_sram_addr   request address (current fetch PC)
//   inst_sram_wdata  tied to 0
//   inst_sram_rdata  read data, valid the cycle after the request
// -----------------------------------------------------------------------------
`ifndef BR_WD
`define BR_WD 33
`endif

module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`BR_WD-1:0] br_bus,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst,
    output logic              id_adel,
    output logic              inst_sram_en,
    output logic [3:0]        inst_sram_wen,
    output logic [31:0]       inst_sram_addr,
    output logic [31:0]       inst_sram_wdata,
    input  logic [31:0]       inst_sram_rdata
);

    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Redirect bus fields
    logic        br_e;
    logic [31:0] br_addr;
    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Fetch state
    logic [31:0] fetch_pc;
    logic        halted;

    // Request pipeline register: describes the request whose response
    // (real or pseudo) arrives in the current cycle.
    logic        inflight;
    logic [31:0] req_pc;
    logic        req_adel;

    // Queue storage and bookkeeping
    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_inst [DEPTH];
    logic             q_adel [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             pop;
    logic             push;
    logic             kill;
    logic             issue;
    logic             aligned;
    logic [PTR_W+1:0] occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign id_valid = (count != '0);
    assign kill     = br_e;
    // A redirect flushes the queue, so a pop in that cycle is meaningless.
    assign pop      = id_valid & id_ready & ~br_e;
    assign push     = inflight & ~kill;
    assign aligned  = (fetch_pc[1:0] == 2'b00);

    // Slots already committed after this cycle: queued entries plus the
    // in-flight response, minus the entry leaving now. A new request is only
    // allowed if it is guaranteed a slot when its response lands.
    assign occupancy = (PTR_W+2)'(count) + (PTR_W+2)'(inflight) - (PTR_W+2)'(pop);
    assign issue     = ~rst & ~br_e & ~halted & (occupancy < DEPTH_W);

    // A misaligned fetch still counts as an issue (it produces a pseudo
    // response carrying the exception) but never reaches the SRAM.
    assign inst_sram_en    = issue & aligned;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // Head entry straight from registers; forced to zero when empty.
    assign id_pc   = id_valid ? q_pc[rd_ptr]   : 32'h0000_0000;
    assign id_inst = id_valid ? q_inst[rd_ptr] : 32'h0000_0000;
    assign id_adel = id_valid ? q_adel[rd_ptr] : 1'b0;

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
            inflight <= 1'b0;
            req_pc   <= 32'h0000_0000;
            req_adel <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            req_pc   <= fetch_pc;
            req_adel <= ~aligned;

            if (br_e) begin
                fetch_pc <= br_addr;
                halted   <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) begin
                    if (aligned) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end else begin
                        // Stop after the exception entry until redirected.
                        halted <= 1'b1;
                    end
                end

                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

    // Queue storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[wr_ptr]   <= req_pc;
            q_inst[wr_ptr] <= req_adel ? 32'h0000_0000 : inst_sram_rdata;
            q_adel[wr_ptr] <= req_adel;
        end
    end

endmodule
